// File: rtl/demux3_reg.sv
// demux3_reg: registered 1-to-3 demux with a valid/ready handshake per channel.
// Define DEMUX3_BROADCAST_EN to turn select 3 into a broadcast to all channels.
module demux3_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  output logic             err,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [WIDTH-1:0] y2_q, y2_d;
  logic [2:0]       v_q, v_d;
  logic [2:0]       rdy;
  logic [2:0]       space;
  logic [2:0]       load;
  logic             xfer;

  assign rdy   = {r2, r1, r0};
  assign space = ~v_q | rdy;

  // ready follows the space of the selected channel(s), never in_valid
  always_comb begin
    in_ready = 1'b0;
    unique case (s)
      2'd0: in_ready = space[0];
      2'd1: in_ready = space[1];
      2'd2: in_ready = space[2];
      2'd3: begin
`ifdef DEMUX3_BROADCAST_EN
        in_ready = &space;
`else
        in_ready = 1'b1;
`endif
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign xfer = in_valid & in_ready;

  // one-hot (or all-hot for broadcast) load strobes for the channels
  always_comb begin
    load = 3'b000;
    if (xfer) begin
      unique case (s)
        2'd0: load = 3'b001;
        2'd1: load = 3'b010;
        2'd2: load = 3'b100;
        2'd3: begin
`ifdef DEMUX3_BROADCAST_EN
          load = 3'b111;
`else
          load = 3'b000;
`endif
        end
        default: load = 3'b000;
      endcase
    end
  end

  // a load wins over a same-cycle drain, giving pass-through refill
  always_comb begin
    y0_d = load[0] ? d : y0_q;
    y1_d = load[1] ? d : y1_q;
    y2_d = load[2] ? d : y2_q;
    v_d  = load | (v_q & ~rdy);
  end

  // channel holding registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y0_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      v_q  <= '0;
    end else begin
      y0_q <= y0_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      v_q  <= v_d;
    end
  end

  assign y0 = y0_q;
  assign y1 = y1_q;
  assign y2 = y2_q;
  assign v0 = v_q[0];
  assign v1 = v_q[1];
  assign v2 = v_q[2];

`ifdef DEMUX3_BROADCAST_EN
  assign err      = 1'b0;
  assign drop_cnt = '0;
`else
  logic             err_q, err_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // accepted select-3 words are dropped, flagged and counted
  always_comb begin
    err_d      = err_q;
    drop_cnt_d = drop_cnt_q;
    if (xfer && s == 2'd3) begin
      err_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}})
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // sticky error and saturating drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err      = err_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/demux3_reg.md
Name: demux3_reg

Overview:
- Registered 1-to-3 demultiplexer for the multicycle datapath. It is the distribution counterpart of the 3-input result mux.
- Takes one WIDTH-bit source word plus a 2-bit destination select and steers the word into one of three output holding registers.
- Each output has its own valid/ready handshake, so consumers such as the IR, MDR and ALUOut latches can accept data on later cycles.
- Illegal selects are counted and flagged instead of being silently lost.

Parameters:
- WIDTH, 16, data width of the input word and of each output channel.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- d  in  WIDTH  source data word.
- s  in  2  destination select: 0 to y0, 1 to y1, 2 to y2, 3 is illegal (see Optional Feature).
- in_valid  in  1  d/s are valid this cycle.
- in_ready  out  1  demux accepts d this cycle.
- y0, y1, y2  out  WIDTH  channel holding registers.
- v0, v1, v2  out  1  channel k holds an undelivered word.
- r0, r1, r2  in  1  consumer k takes the word this cycle.
- err  out  1  sticky: at least one illegal select has been accepted.
- drop_cnt  out  CNT_W  number of words discarded for illegal select, saturating.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - y0..y2 = 0, v0..v2 = 0, err = 0, drop_cnt = 0.
  - Any word held at the moment of reset is discarded.
  - Outputs leave reset on the first rising clk edge after reset_n rises.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready at a rising edge.
  - Output transfer on channel k occurs when vk & rk at a rising edge.
- Space:
  - Channel k has space when vk=0, or when vk=1 & rk=1 in the same cycle (pass-through refill).
- in_ready is combinational from s, v*, r*. It must not depend on in_valid.
  - s=0..2: in_ready = space of channel s.
  - s=3 without the feature: in_ready = 1.
- Latency:
  - A word accepted at edge N appears on yk with vk=1 after edge N, so it is visible in cycle N+1.
  - There is no combinational path from d to yk.
- Channel update at each edge:
  - If an input transfer targets k: yk <= d, vk <= 1, regardless of a simultaneous output transfer on k.
  - Else if an output transfer on k: vk <= 0, and yk holds its last value.
  - Else: no change.
- Ordering:
  - Channels are independent. Per channel, words are delivered in acceptance order.
  - Depth is 1 per channel, so the protocol can never overwrite an undelivered word.
- Illegal select, without the feature: an accepted s=3 word is dropped.
  - err <= 1.
  - drop_cnt <= drop_cnt+1, saturating at 2^CNT_W-1.
  - No vk changes.
- vk and yk do not depend on in_valid unless a transfer happens. If in_valid=0, s and d are ignored.
- err and drop_cnt clear only on reset.

Optional Feature:
- Macro DEMUX3_BROADCAST_EN.
- When defined, s=3 means broadcast:
  - in_ready = space0 & space1 & space2.
  - On transfer, y0, y1 and y2 all load d and v0..v2 are set.
  - err and drop_cnt are never incremented. They remain present and are tied to 0.
- When undefined, s=3 follows the illegal-select rule above.

Test Plan:
- Reset check: assert reset_n=0 mid-cycle while v1=1 → immediately y*=0, v*=0, err=0, drop_cnt=0, without waiting for a clock edge.
- Basic steer: d=16'h1234 s=0, then d=16'habcd s=1, then d=16'h1111 s=2, all r*=1 → y0=1234, y1=abcd, y2=1111, each valid exactly one cycle after its accept.
- Backpressure: r1=0, send 16'habcd with s=1 and then 16'h5555 with s=1.
  - First word is accepted and in_ready goes 0 for s=1.
  - y1 stays abcd until r1=1.
  - On that same edge 5555 is accepted and y1=5555 next cycle, with v1 continuously 1.
- Independence: hold v0=1 with r0=0 and send s=2 d=16'h2222 → in_ready=1, y2=2222, y0 unchanged.
- Illegal select (feature off): send 300 words with s=3 → in_ready=1 each cycle, v* never set, err=1 after the first, drop_cnt saturates at 255.
- Broadcast (DEMUX3_BROADCAST_EN):
  - With all channels empty, s=3 d=16'h00ff → y0=y1=y2=00ff and v0..v2=1.
  - With v2=1 and r2=0, s=3 → in_ready=0 until channel 2 drains.
